// File: rtl/pop_mode_scheduler_if.sv
// Handshake/bus bundle for the POP mode scheduler: programming port,
// POP timer events, STM32 tuning request and the scheduler outputs.
interface pop_mode_scheduler_if #(
  parameter int DWELL_W = 12
);
  logic               start;
  logic               abort;
  logic               prog_wr;
  logic [1:0]         prog_addr;
  logic [2:0]         prog_mode;
  logic [DWELL_W-1:0] prog_dwell;
  logic               cycle_end;
  logic               laser_tuning;
  logic [2:0]         mode;
  logic               timers_reset;
  logic               sample_gate;
  logic               busy;
  logic               done;
  logic [1:0]         entry;

  modport master (
    output start, abort, prog_wr, prog_addr, prog_mode, prog_dwell,
           cycle_end, laser_tuning,
    input  mode, timers_reset, sample_gate, busy, done, entry
  );

  modport slave (
    input  start, abort, prog_wr, prog_addr, prog_mode, prog_dwell,
           cycle_end, laser_tuning,
    output mode, timers_reset, sample_gate, busy, done, entry
  );
endinterface

// File: rtl/pop_mode_scheduler.sv
// POP mode scheduler: walks a 4-entry {mode, dwell} table, holding each mode
// for a dwell of completed POP cycles, restarting the POP timers and blanking
// ADC samples while the front end settles after every mode change.
// Laser tuning pre-empts the sequence; abort returns to IDLE.
// Optional build macro POP_SCHED_SKIP_ZERO_EN: entries with dwell 0 are skipped
// (otherwise a dwell of 0 behaves as a dwell of 1).
module pop_mode_scheduler #(
  parameter int DWELL_W       = 12,
  parameter int SETTLE_CYCLES = 250,
  parameter int LOOPS         = 0
) (
  input  logic                clk_2M5,
  input  logic                reset_n,
  pop_mode_scheduler_if.slave bus
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int LW = 16;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_RUN, S_TUNE, S_DONE
  } state_t;

  state_t                   state_q, state_d;
  logic [1:0]               entry_q, entry_d;
  logic [DWELL_W-1:0]       dwell_q, dwell_d;
  logic [SW-1:0]            settle_q, settle_d;
  logic [LW-1:0]            loop_q, loop_d;
  logic [2:0]               mode_q, mode_d;
  logic                     tr_q, tr_d;
  logic                     sg_q, sg_d;
  logic [3:0][2:0]          tbl_mode_q;
  logic [3:0][DWELL_W-1:0]  tbl_dwell_q;

  logic [DWELL_W-1:0]       cur_dwell, dwell_nxt;
  logic                     dwell_hit;
  logic [1:0]               adv_entry, start_entry;
  logic [LW-1:0]            adv_loop;
  logic                     adv_done, start_empty;

  // A programmed dwell of 0 can only reach RUN in the default build; it counts as 1.
  assign cur_dwell = (tbl_dwell_q[entry_q] == '0) ? DWELL_W'(1) : tbl_dwell_q[entry_q];
  assign dwell_nxt = (dwell_q == '1) ? dwell_q : dwell_q + 1'b1;
  assign dwell_hit = (dwell_nxt >= cur_dwell);

`ifdef POP_SCHED_SKIP_ZERO_EN
  logic [1:0]    scan_pos;
  logic [LW-1:0] scan_loop;
  logic          scan_found, scan_done;

  // Scan forward for the next non-zero entry, counting a pass each time the scan wraps.
  always_comb begin
    scan_pos   = entry_q;
    scan_loop  = loop_q;
    scan_found = 1'b0;
    scan_done  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (!scan_found && !scan_done) begin
        if (scan_pos == 2'd3) begin
          if (scan_loop != '1) scan_loop = scan_loop + 1'b1;
          if (LOOPS != 0 && scan_loop == LW'(LOOPS)) scan_done = 1'b1;
        end
        scan_pos = scan_pos + 2'd1;
        if (!scan_done && tbl_dwell_q[scan_pos] != '0) scan_found = 1'b1;
      end
    end
    adv_entry = scan_pos;
    adv_loop  = scan_loop;
    adv_done  = scan_done || !scan_found;
  end

  // First non-zero entry for a fresh start; an all-zero table goes straight to DONE.
  always_comb begin
    start_entry = 2'd0;
    start_empty = 1'b1;
    for (int k = 3; k >= 0; k--) begin
      if (tbl_dwell_q[k] != '0) begin
        start_entry = 2'(k);
        start_empty = 1'b0;
      end
    end
  end
`else
  // Plain successor: next entry, or wrap to 0 and count a completed pass.
  always_comb begin
    adv_entry = entry_q + 2'd1;
    adv_loop  = loop_q;
    adv_done  = 1'b0;
    if (entry_q == 2'd3) begin
      if (loop_q != '1) adv_loop = loop_q + 1'b1;
      adv_done = (LOOPS != 0) && (adv_loop == LW'(LOOPS));
    end
  end

  assign start_entry = 2'd0;
  assign start_empty = 1'b0;
`endif

  // Next-state and registered-output decode; abort outranks everything.
  always_comb begin
    state_d  = state_q;
    entry_d  = entry_q;
    dwell_d  = dwell_q;
    settle_d = settle_q;
    loop_d   = loop_q;
    mode_d   = mode_q;
    tr_d     = 1'b0;
    if (bus.abort) begin
      state_d = S_IDLE;
      mode_d  = 3'd2;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            loop_d  = '0;
            entry_d = start_entry;
            state_d = start_empty ? S_DONE : S_LOAD;
          end
        end
        S_LOAD: begin
          mode_d   = tbl_mode_q[entry_q];
          tr_d     = 1'b1;
          dwell_d  = '0;
          settle_d = '0;
          state_d  = S_SETTLE;
        end
        S_SETTLE: begin
          if (bus.laser_tuning) begin
            state_d = S_TUNE;
            mode_d  = 3'd1;
          end else if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
            state_d = S_RUN;
          end else begin
            settle_d = settle_q + 1'b1;
          end
        end
        S_RUN: begin
          if (bus.laser_tuning) begin
            state_d = S_TUNE;
            mode_d  = 3'd1;
          end else if (bus.cycle_end) begin
            if (dwell_hit) begin
              loop_d = adv_loop;
              if (adv_done) begin
                state_d = S_DONE;
              end else begin
                entry_d = adv_entry;
                state_d = S_LOAD;
              end
            end else begin
              dwell_d = dwell_nxt;
            end
          end
        end
        S_TUNE: begin
          // Same entry is reloaded: fresh timers restart, settle and dwell.
          if (!bus.laser_tuning) state_d = S_LOAD;
        end
        default: state_d = S_IDLE;
      endcase
    end
    sg_d = (state_d == S_RUN);
  end

  // Control state and registered outputs.
  always_ff @(posedge clk_2M5 or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      entry_q  <= 2'd0;
      dwell_q  <= '0;
      settle_q <= '0;
      loop_q   <= '0;
      mode_q   <= 3'd2;
      tr_q     <= 1'b0;
      sg_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      entry_q  <= entry_d;
      dwell_q  <= dwell_d;
      settle_q <= settle_d;
      loop_q   <= loop_d;
      mode_q   <= mode_d;
      tr_q     <= tr_d;
      sg_q     <= sg_d;
    end
  end

  // Program table; only writable while the sequence is not running.
  always_ff @(posedge clk_2M5 or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) begin
        tbl_mode_q[i]  <= 3'd2;
        tbl_dwell_q[i] <= DWELL_W'(1);
      end
    end else if (bus.prog_wr && (state_q == S_IDLE || state_q == S_DONE)) begin
      tbl_mode_q[bus.prog_addr]  <= bus.prog_mode;
      tbl_dwell_q[bus.prog_addr] <= bus.prog_dwell;
    end
  end

  assign bus.mode         = mode_q;
  assign bus.timers_reset = tr_q;
  assign bus.sample_gate  = sg_q;
  assign bus.busy         = (state_q != S_IDLE) && (state_q != S_DONE);
  assign bus.done         = (state_q == S_DONE);
  assign bus.entry        = entry_q;

endmodule
